// File: rtl/ldst_router_pkg.sv
// rtl/ldst_router_pkg.sv - shared types and default address map for the ldst router
package ldst_router_pkg;

  localparam int PTR_W  = 30;
  localparam int WORD_W = 32;

  typedef logic [PTR_W-1:0]  ptr;
  typedef logic [WORD_W-1:0] word;

  typedef enum logic [2:0] {
    TGT_L1D = 3'd0,
    TGT_IO  = 3'd1
  } ldst_tgt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FAULT,
    ST_TOUT
  } ldst_state_t;

  // Target 0 sits in the low slice: the first 512 MiB go to L1d, the rest falls through to IO.
  localparam logic [2*PTR_W-1:0] DEF_TGT_BASE = {30'h0000_0000, 30'h0000_0000};
  localparam logic [2*PTR_W-1:0] DEF_TGT_MASK = {30'h0000_0000, 30'h3800_0000};

endpackage

// File: rtl/ldst_addr_decode.sv
// rtl/ldst_addr_decode.sv - fixed-priority base/mask address matcher
module ldst_addr_decode import ldst_router_pkg::*; #(
  parameter int                     NTGT     = 2,
  parameter logic [NTGT*PTR_W-1:0]  TGT_BASE = DEF_TGT_BASE,
  parameter logic [NTGT*PTR_W-1:0]  TGT_MASK = DEF_TGT_MASK,
  localparam int                    SEL_W    = (NTGT > 1) ? $clog2(NTGT) : 1
) (
  input  logic [PTR_W-1:0] addr,
  output logic [SEL_W-1:0] sel,
  output logic             miss
);

  logic [NTGT-1:0] hit;

  always_comb begin
    for (int i = 0; i < NTGT; i++) begin
      hit[i] = ((addr & TGT_MASK[i*PTR_W +: PTR_W]) == TGT_BASE[i*PTR_W +: PTR_W]);
    end
  end

  // Walk from the top down so the lowest-index hit is the last one written.
  always_comb begin
    sel  = '0;
    miss = 1'b1;
    for (int i = NTGT - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel  = SEL_W'(i);
        miss = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ldst_router.sv
// rtl/ldst_router.sv - routes the core ldst port to one of NTGT memory targets with fault/timeout responses
module ldst_router import ldst_router_pkg::*; #(
  parameter int                    NTGT     = 2,
  parameter logic [NTGT*PTR_W-1:0] TGT_BASE = DEF_TGT_BASE,
  parameter logic [NTGT*PTR_W-1:0] TGT_MASK = DEF_TGT_MASK,
  parameter int                    TIMEOUT  = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ldst_start,
  input  logic                   ldst_write,
  input  logic [PTR_W-1:0]       ldst_addr,
  input  logic [WORD_W-1:0]      ldst_data_wr,
  output logic                   ldst_ready,
  output logic                   ldst_fault,
  output logic [WORD_W-1:0]      ldst_data_rd,
  output logic [NTGT-1:0]        tgt_start,
  output logic                   tgt_write,
  output logic [PTR_W-1:0]       tgt_addr,
  output logic [WORD_W-1:0]      tgt_data_wr,
  output logic [NTGT-1:0]        tgt_abort,
  input  logic [NTGT-1:0]        tgt_ready,
  input  logic [NTGT*WORD_W-1:0] tgt_data_rd
);

  localparam int SEL_W = (NTGT > 1) ? $clog2(NTGT) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  ldst_state_t       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  dec_sel;
  logic              dec_miss;
  logic              accept;
  logic              sel_rdy;
  logic [WORD_W-1:0] sel_data;

  assign tgt_write   = ldst_write;
  assign tgt_addr    = ldst_addr;
  assign tgt_data_wr = ldst_data_wr;

  ldst_addr_decode #(
    .NTGT     (NTGT),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_decode (
    .addr (ldst_addr),
    .sel  (dec_sel),
    .miss (dec_miss)
  );

  always_comb begin
    sel_rdy  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NTGT; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_rdy  = tgt_ready[i];
        sel_data = tgt_data_rd[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_BUSY: begin
        // A ready in the expiry cycle wins over the timeout.
        if (sel_rdy) begin
          state_d = ST_IDLE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d = ST_TOUT;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FAULT, ST_TOUT: state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d = dec_miss ? ST_FAULT : ST_BUSY;
      sel_d   = dec_miss ? sel_q : dec_sel;
      cnt_d   = '0;
    end
  end

  always_comb begin
    ldst_ready   = 1'b0;
    ldst_fault   = 1'b0;
    ldst_data_rd = '0;
    tgt_abort    = '0;
    unique case (state_q)
      ST_BUSY: begin
        ldst_ready = sel_rdy;
        if (sel_rdy) ldst_data_rd = sel_data;
      end
      ST_FAULT: begin
        ldst_ready = 1'b1;
        ldst_fault = 1'b1;
      end
      ST_TOUT: begin
        ldst_ready = 1'b1;
        ldst_fault = 1'b1;
        tgt_abort  = NTGT'(1) << sel_q;
      end
      default: ;
    endcase
    // A completion cycle doubles as an accept slot for the next request.
    accept    = rst_n && ldst_start && (state_q == ST_IDLE || ldst_ready);
    tgt_start = (accept && !dec_miss) ? (NTGT'(1) << dec_sel) : '0;
  end

endmodule
